// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind the UART receiver: sync hunt, length, payload, XOR checksum, replay on valid/ready.
// Optional inter-byte timeout is built when UART_FRAME_TIMEOUT_EN is defined.
module uart_rx_frame_ctrl #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 208340,
  parameter int         CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_byte,
  input  logic             rx_valid,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_ok,
  output logic             frame_err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int IDX_W  = $clog2(MAX_LEN + 1);
  localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {IDLE, LEN, PAY, CHK, OUT} state_t;

  state_t           state;
  logic [7:0]       mem [0:MAX_LEN-1];
  logic [IDX_W-1:0] len;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] rd_nxt;
  logic [7:0]       chk;
  logic             len_bad;
  logic             chk_good;
  logic             fire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign len_bad  = (rx_byte == 8'd0) || (rx_byte > 8'(MAX_LEN));
  assign chk_good = (rx_byte == chk);
  assign fire     = out_valid && out_ready;
  assign rd_nxt   = rd_idx + IDX_W'(1);
  assign busy     = (state != IDLE);

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TMR_W-1:0] timer;
  logic             in_rx;
  logic             tmo_hit;

  assign in_rx   = (state == LEN) || (state == PAY) || (state == CHK);
  assign tmo_hit = in_rx && !rx_valid && (timer == TMR_W'(TIMEOUT_CYC - 1));
`endif

  // Datapath: frame buffer, running checksum and indices carry no reset
  always_ff @(posedge clk) begin
    if (rx_valid) begin
      case (state)
        LEN: begin
          len    <= IDX_W'(rx_byte);
          chk    <= rx_byte;
          wr_idx <= '0;
        end
        PAY: begin
          mem[wr_idx[ADDR_W-1:0]] <= rx_byte;
          chk    <= chk ^ rx_byte;
          wr_idx <= wr_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
    if (state == CHK && rx_valid)
      rd_idx <= '0;
    else if (state == OUT && fire)
      rd_idx <= rd_nxt;
  end

  // Control FSM with registered stream and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'b00;
      drop_cnt  <= '0;
`ifdef UART_FRAME_TIMEOUT_EN
      timer     <= '0;
`endif
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: if (rx_valid && rx_byte == SYNC_BYTE) state <= LEN;
        LEN: if (rx_valid) begin
          if (len_bad) begin
            frame_err <= 1'b1;
            err_code  <= 2'b01;
            state     <= IDLE;
          end else begin
            state <= PAY;
          end
        end
        PAY: if (rx_valid && (wr_idx + IDX_W'(1) == len)) state <= CHK;
        CHK: if (rx_valid) begin
          if (chk_good) begin
            frame_ok  <= 1'b1;
            out_valid <= 1'b1;
            out_data  <= mem[ADDR_W'(0)];
            out_last  <= (len == IDX_W'(1));
            state     <= OUT;
          end else begin
            frame_err <= 1'b1;
            err_code  <= 2'b10;
            state     <= IDLE;
          end
        end
        OUT: begin
          // Bytes arriving while draining are discarded, never resynced
          if (rx_valid) drop_cnt <= sat_inc(drop_cnt);
          if (fire) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= IDLE;
            end else begin
              out_data <= mem[rd_nxt[ADDR_W-1:0]];
              out_last <= (rd_nxt == len - IDX_W'(1));
            end
          end
        end
        default: state <= IDLE;
      endcase
`ifdef UART_FRAME_TIMEOUT_EN
      if (rx_valid || !in_rx) timer <= '0;
      else                    timer <= timer + TMR_W'(1);
      // A byte in the expiry cycle wins because tmo_hit requires !rx_valid
      if (tmo_hit) begin
        frame_err <= 1'b1;
        err_code  <= 2'b11;
        state     <= IDLE;
      end
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: directed scenarios plus random frames checked against a frame-level model.
module tb_uart_rx_frame_ctrl;

  localparam int MAX_LEN = 16;
  localparam int CNT_W   = 8;
`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TMO = 100;
`else
  localparam int TMO = 208340;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       rx_byte;
  logic             rx_valid;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_last;
  logic             out_ready = 1'b0;
  logic             busy;
  logic             frame_ok;
  logic             frame_err;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] drop_cnt;

  uart_rx_frame_ctrl #(
    .SYNC_BYTE(8'hA5), .MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TMO), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor on the falling edge, away from the stimulus and DUT edges
  logic [7:0] got_q[$];
  logic       last_q[$];
  int         ok_cnt, err_cnt, vld_cnt, stab_err, lat_err;
  logic [1:0] last_err;
  logic       prev_vld = 1'b0, prev_rdy = 1'b0, prev_last = 1'b0;
  logic [7:0] prev_data = 8'h00;

  initial begin
    ok_cnt = 0; err_cnt = 0; vld_cnt = 0; stab_err = 0; lat_err = 0; last_err = 2'b00;
  end

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      got_q.push_back(out_data);
      last_q.push_back(out_last);
    end
    if (out_valid) vld_cnt++;
    if (frame_ok) begin
      ok_cnt++;
      if (!out_valid) lat_err++;
    end
    if (frame_err) begin
      err_cnt++;
      last_err = err_code;
    end
    if (prev_vld && !prev_rdy && out_valid && (out_data !== prev_data || out_last !== prev_last))
      stab_err++;
    prev_vld = out_valid; prev_rdy = out_ready; prev_data = out_data; prev_last = out_last;
  end

  // Stimulus: every step lands 1 time unit after a rising edge
  bit         rdy_rand = 1'b0;
  logic       rdy_val  = 1'b0;
  logic [7:0] seq[$];

  task automatic step();
    @(posedge clk);
    #1;
    rx_valid  = 1'b0;
    out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    step();
  endtask

  task automatic send_seq();
    foreach (seq[i]) send_byte(seq[i]);
  endtask

  task automatic clear_mon();
    got_q.delete();
    last_q.delete();
    ok_cnt = 0; err_cnt = 0; vld_cnt = 0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int k;
    k = 0;
    while (busy && k < limit) begin
      step();
      k++;
    end
    if (busy) check({tag, "_idle_timeout"}, 32'(busy), 32'd0);
    step();
  endtask

  task automatic good_short(input string tag);
    clear_mon();
    seq = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
    send_seq();
    wait_idle(tag, 200);
    check({tag, "_ok"}, ok_cnt, 1);
    check({tag, "_n"}, got_q.size(), 1);
    if (got_q.size() > 0) check({tag, "_d0"}, got_q[0], 8'h7E);
  endtask

  // Frame-level reference: outcome follows directly from the frame contents
  task automatic random_frame(input int n);
    int         kind, flen, gap;
    logic [7:0] pay[$];
    logic [7:0] cs, b;
    logic [1:0] exp_code;
    kind = $urandom_range(0, 2);
    clear_mon();
    repeat ($urandom_range(0, 2)) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h00;
      send_byte(b);
    end
    if (kind == 1) flen = $urandom_range(0, 1) ? 0 : $urandom_range(MAX_LEN + 1, 255);
    else           flen = $urandom_range(1, MAX_LEN);
    gap = $urandom_range(0, 3);
    send_byte(8'hA5);
    repeat (gap) step();
    send_byte(8'(flen));
    exp_code = 2'b01;
    if (kind != 1) begin
      cs = 8'(flen);
      for (int i = 0; i < flen; i++) begin
        pay.push_back(8'($urandom));
        cs ^= pay[i];
        repeat ($urandom_range(0, 3)) step();
        send_byte(pay[i]);
      end
      if (kind == 2) begin
        cs ^= 8'($urandom_range(1, 255));
        exp_code = 2'b10;
      end
      repeat ($urandom_range(0, 3)) step();
      send_byte(cs);
    end
    wait_idle($sformatf("rnd%0d", n), 1000);
    if (kind == 0) begin
      check($sformatf("rnd%0d_ok", n), ok_cnt, 1);
      check($sformatf("rnd%0d_err", n), err_cnt, 0);
      check($sformatf("rnd%0d_len", n), got_q.size(), flen);
      for (int i = 0; i < flen && i < got_q.size(); i++) begin
        check($sformatf("rnd%0d_d%0d", n, i), got_q[i], pay[i]);
        check($sformatf("rnd%0d_l%0d", n, i), last_q[i], (i == flen - 1));
      end
    end else begin
      check($sformatf("rnd%0d_err", n), err_cnt, 1);
      check($sformatf("rnd%0d_code", n), last_err, exp_code);
      check($sformatf("rnd%0d_vld", n), vld_cnt, 0);
      check($sformatf("rnd%0d_ok", n), ok_cnt, 0);
    end
  endtask

  initial begin
    int unstable;
    rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00;
    repeat (3) step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_ok", frame_ok, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_out_data", out_data, 0);
    rst = 1'b0;
    rdy_val = 1'b1;
    step();

    // Good 3-byte frame, streamed on consecutive cycles
    clear_mon();
    seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33};
    send_seq();
    check("good_busy_pay", busy, 1);
    send_byte(8'h03);
    check("good_frame_ok", frame_ok, 1);
    check("good_vld0", out_valid, 1);
    check("good_d0", out_data, 8'h11);
    check("good_l0", out_last, 0);
    step();
    check("good_frame_ok_pulse", frame_ok, 0);
    check("good_d1", out_data, 8'h22);
    check("good_l1", out_last, 0);
    step();
    check("good_d2", out_data, 8'h33);
    check("good_l2", out_last, 1);
    step();
    check("good_vld_end", out_valid, 0);
    check("good_busy_end", busy, 0);
    step();
    check("good_ok_cnt", ok_cnt, 1);

    // Bad lengths: zero and above MAX_LEN
    clear_mon();
    send_byte(8'hA5);
    send_byte(8'h00);
    check("blen0_err", frame_err, 1);
    check("blen0_code", err_code, 2'b01);
    step();
    send_byte(8'hA5);
    send_byte(8'h11);
    check("blen17_err", frame_err, 1);
    check("blen17_code", err_code, 2'b01);
    step();
    check("blen_busy", busy, 0);
    check("blen_err_cnt", err_cnt, 2);
    check("blen_vld", vld_cnt, 0);

    // Bad checksum (correct would be FD), then a good frame
    clear_mon();
    seq = '{8'hA5, 8'h02, 8'hAA, 8'h55, 8'h00};
    send_seq();
    check("bchk_err", frame_err, 1);
    check("bchk_code", err_code, 2'b10);
    step();
    check("bchk_busy", busy, 0);
    check("bchk_vld", vld_cnt, 0);
    good_short("after_bchk");
    check("after_bchk_code", err_code, 2'b10);

    // Backpressure with drops during OUT
    rdy_val = 1'b0;
    step();
    clear_mon();
    seq = '{8'hA5, 8'h02, 8'h5A, 8'hC3, 8'h9B};
    send_seq();
    unstable = 0;
    repeat (10) begin
      step();
      if (!out_valid || out_data !== 8'h5A || out_last !== 1'b0) unstable++;
    end
    check("bp_hold", unstable, 0);
    send_byte(8'hA5);
    send_byte(8'($urandom));
    send_byte(8'h02);
    check("bp_drop_cnt", drop_cnt, 3);
    check("bp_data_after_drop", out_data, 8'h5A);
    check("bp_busy", busy, 1);
    rdy_val = 1'b1;
    wait_idle("bp", 50);
    check("bp_n", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("bp_d0", got_q[0], 8'h5A);
      check("bp_d1", got_q[1], 8'hC3);
      check("bp_l0", last_q[0], 0);
      check("bp_l1", last_q[1], 1);
    end

    // Final transfer coinciding with an incoming byte
    seq = '{8'hA5, 8'h01, 8'h3C, 8'h3D};
    send_seq();
    check("sim_last", out_last, 1);
    send_byte(8'hA5);
    check("sim_busy", busy, 0);
    check("sim_vld", out_valid, 0);
    check("sim_drop_cnt", drop_cnt, 4);

    // Reset mid-payload
    seq = '{8'hA5, 8'h04, 8'h01, 8'h02};
    send_seq();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_busy", busy, 0);
    check("mrst_code", err_code, 0);
    check("mrst_vld", out_valid, 0);
    check("mrst_drop", drop_cnt, 0);
    good_short("after_rst");

`ifdef UART_FRAME_TIMEOUT_EN
    begin
      int seen;
      seen = -1;
      clear_mon();
      seq = '{8'hA5, 8'h04, 8'h01};
      send_seq();
      for (int k = 1; k <= 150; k++) begin
        step();
        if (frame_err) begin
          seen = k;
          break;
        end
      end
      check("tmo_cycles", seen, TMO);
      check("tmo_code", err_code, 2'b11);
      step();
      check("tmo_busy", busy, 0);
    end
`endif

    // Randomized frames with random backpressure
    rdy_rand = 1'b1;
    for (int n = 0; n < 40; n++) random_frame(n);
    rdy_rand = 1'b0;
    step();
    check("stable_under_bp", stab_err, 0);
    check("ok_with_valid", lat_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
